// File: rtl/dlsc_axi_rd_splitter_pkg.sv
// Shared types and elaboration helpers for the AXI read burst splitter.
package dlsc_axi_rd_splitter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SPLIT = 1'b1
    } split_state_t;

    // log2 of the beat size in bytes; converts a beat count into an address step
    function automatic int beat_shift(input int data_bits);
        return $clog2(data_bits / 8);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dlsc_axi_rd_splitter_track.sv
// Purpose: 1-bit FIFO holding the "final sub-burst" flag of each issued sub-burst.
// Latency: write visible at the head one cycle after push; pop takes effect next edge.
// Backpressure: full_o must gate the writer; pushing while full is never issued.
module dlsc_axi_rd_splitter_track #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push_i,
    input  logic din_i,
    input  logic pop_i,
    output logic dout_o,
    output logic full_o,
    output logic empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    logic [DEPTH-1:0] mem_q;
    logic [PW-1:0]    wr_q;
    logic [PW-1:0]    rd_q;
    logic [PW:0]      cnt_q;

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign dout_o  = mem_q[rd_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= wr_q + PW'(1);
            end
            if (pop_i) begin
                rd_q <= rd_q + PW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/dlsc_axi_rd_splitter.sv
// Purpose: split master read bursts into router-legal sub-bursts, merging r_last back.
// Latency: first sub-burst the cycle after command accept; data path is combinational.
// Backpressure: sub-bursts stall while the tracking FIFO is full; r channel passes ready through.
module dlsc_axi_rd_splitter
    import dlsc_axi_rd_splitter_pkg::*;
#(
    parameter int ADDR     = 32,
    parameter int DATA     = 32,
    parameter int IN_LEN   = 8,
    parameter int OUT_LEN  = 4,
    parameter int BOUNDARY = 12,
    parameter int MOT      = 4
) (
    input  logic                clk,
    input  logic                rst_n,

    output logic                in_ar_ready,
    input  logic                in_ar_valid,
    input  logic [ADDR-1:0]     in_ar_addr,
    input  logic [IN_LEN-1:0]   in_ar_len,

    input  logic                in_r_ready,
    output logic                in_r_valid,
    output logic                in_r_last,
    output logic [DATA-1:0]     in_r_data,
    output logic [1:0]          in_r_resp,

    input  logic                out_ar_ready,
    output logic                out_ar_valid,
    output logic [ADDR-1:0]     out_ar_addr,
    output logic [OUT_LEN-1:0]  out_ar_len,

    output logic                out_r_ready,
    input  logic                out_r_valid,
    input  logic                out_r_last,
    input  logic [DATA-1:0]     out_r_data,
    input  logic [1:0]          out_r_resp
);

    localparam int SHIFT = beat_shift(DATA);
    localparam int REM_W = IN_LEN + 1;
    localparam int CW    = max_int(max_int(REM_W, OUT_LEN + 1), BOUNDARY + 1);

    split_state_t      state_q, state_d;
    logic [ADDR-1:0]   addr_q, addr_d;
    logic [REM_W-1:0]  rem_q, rem_d;

    logic [CW-1:0]     rem_w;
    logic [CW-1:0]     max_w;
    logic [CW-1:0]     bnd_w;
    logic [CW-1:0]     beats_w;
    logic              last_w;

    logic              trk_push;
    logic              trk_pop;
    logic              trk_head;
    logic              trk_full;
    logic              trk_empty;

    // Sub-burst size: the smallest of what is left, the router limit and the boundary room.
    always_comb begin
        rem_w   = CW'(rem_q);
        max_w   = CW'(1) << OUT_LEN;
        bnd_w   = ((CW'(1) << BOUNDARY) - CW'(addr_q[BOUNDARY-1:0])) >> SHIFT;
        beats_w = rem_w;
        if (max_w < beats_w) beats_w = max_w;
        if (bnd_w < beats_w) beats_w = bnd_w;
    end

    assign last_w = (rem_w == beats_w);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rem_d        = rem_q;
        in_ar_ready  = 1'b0;
        out_ar_valid = 1'b0;
        trk_push     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ar_ready = 1'b1;
                if (in_ar_valid) begin
                    addr_d  = in_ar_addr;
                    rem_d   = REM_W'(in_ar_len) + REM_W'(1);
                    state_d = ST_SPLIT;
                end
            end
            ST_SPLIT: begin
                out_ar_valid = !trk_full;
                if (out_ar_valid && out_ar_ready) begin
                    trk_push = 1'b1;
                    addr_d   = addr_q + (ADDR'(beats_w) << SHIFT);
                    rem_d    = rem_q - REM_W'(beats_w);
                    if (last_w) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
        end
    end

    assign out_ar_addr = addr_q;
    assign out_ar_len  = (state_q == ST_SPLIT) ? OUT_LEN'(beats_w - CW'(1)) : '0;

    // Data is only forwarded while a sub-burst is tracked, so its final flag is at the head.
    assign in_r_valid  = out_r_valid & !trk_empty;
    assign out_r_ready = in_r_ready & !trk_empty;
    assign in_r_last   = out_r_last & trk_head & !trk_empty;
    assign in_r_data   = out_r_data;
    assign in_r_resp   = out_r_resp;
    assign trk_pop     = out_r_valid & out_r_ready & out_r_last;

    dlsc_axi_rd_splitter_track #(
        .DEPTH (MOT)
    ) u_track (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (trk_push),
        .din_i   (last_w),
        .pop_i   (trk_pop),
        .dout_o  (trk_head),
        .full_o  (trk_full),
        .empty_o (trk_empty)
    );

endmodule

// File: tb/tb_dlsc_axi_rd_splitter.sv
module tb_dlsc_axi_rd_splitter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_ar_ready, in_ar_valid;
    logic [31:0] in_ar_addr;
    logic [7:0]  in_ar_len;
    logic        in_r_ready, in_r_valid, in_r_last;
    logic [31:0] in_r_data;
    logic [1:0]  in_r_resp;
    logic        out_ar_ready, out_ar_valid;
    logic [31:0] out_ar_addr;
    logic [3:0]  out_ar_len;
    logic        out_r_ready, out_r_valid, out_r_last;
    logic [31:0] out_r_data;
    logic [1:0]  out_r_resp;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] exp_ar_addr[$];
    logic [3:0]  exp_ar_len[$];
    bit          exp_r[$];
    int          pend[$];

    int ar_hs_count = 0;
    bit r_hs_f      = 1'b0;
    int beat_idx    = 0;
    int rcnt        = 0;
    int mcnt        = 0;
    int r_credit    = 1000000;

    always #5 clk = ~clk;

    dlsc_axi_rd_splitter #(
        .ADDR(32), .DATA(32), .IN_LEN(8), .OUT_LEN(4), .BOUNDARY(12), .MOT(4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_ar_ready  (in_ar_ready),
        .in_ar_valid  (in_ar_valid),
        .in_ar_addr   (in_ar_addr),
        .in_ar_len    (in_ar_len),
        .in_r_ready   (in_r_ready),
        .in_r_valid   (in_r_valid),
        .in_r_last    (in_r_last),
        .in_r_data    (in_r_data),
        .in_r_resp    (in_r_resp),
        .out_ar_ready (out_ar_ready),
        .out_ar_valid (out_ar_valid),
        .out_ar_addr  (out_ar_addr),
        .out_ar_len   (out_ar_len),
        .out_r_ready  (out_r_ready),
        .out_r_valid  (out_r_valid),
        .out_r_last   (out_r_last),
        .out_r_data   (out_r_data),
        .out_r_resp   (out_r_resp)
    );

    // Monitors: handshakes seen here complete on the following rising edge.
    always @(negedge clk) begin : mon
        logic [31:0] ea;
        logic [3:0]  el;
        bit          eb;
        r_hs_f = out_r_valid && out_r_ready;
        if (rst_n && out_ar_valid && out_ar_ready) begin
            ar_hs_count++;
            pend.push_back(int'(out_ar_len));
            n_cmp++;
            if (exp_ar_addr.size() == 0) begin
                n_fail++;
                $display("FAIL ar_unexpected: got addr %h len %0d, required no sub-burst", out_ar_addr, out_ar_len);
            end else begin
                ea = exp_ar_addr.pop_front();
                el = exp_ar_len.pop_front();
                if (out_ar_addr !== ea || out_ar_len !== el) begin
                    n_fail++;
                    $display("FAIL ar_cmd: got addr %h len %0d, required addr %h len %0d", out_ar_addr, out_ar_len, ea, el);
                end
            end
        end
        if (rst_n && in_r_valid && in_r_ready) begin
            n_cmp++;
            if (exp_r.size() == 0) begin
                n_fail++;
                $display("FAIL r_unexpected: got beat data %h, required no beat", in_r_data);
            end else begin
                eb = exp_r.pop_front();
                if (in_r_last !== eb || in_r_data !== 32'(mcnt) || in_r_resp !== 2'(mcnt)) begin
                    n_fail++;
                    $display("FAIL r_beat: got last %b data %h resp %0d, required last %b data %h resp %0d",
                             in_r_last, in_r_data, in_r_resp, eb, 32'(mcnt), 2'(mcnt));
                end
            end
            mcnt++;
        end
    end

    // Router data model: answers each accepted sub-burst in order when credit allows.
    always @(posedge clk) begin
        #1;
        if (r_hs_f) begin
            rcnt++;
            if (out_r_last) begin
                if (pend.size() > 0) void'(pend.pop_front());
                beat_idx = 0;
                if (r_credit > 0) r_credit--;
            end else begin
                beat_idx++;
            end
        end
        out_r_valid = (pend.size() > 0) && (r_credit > 0);
        out_r_last  = (pend.size() > 0) && (beat_idx == pend[0]);
        out_r_data  = 32'(rcnt);
        out_r_resp  = 2'(rcnt);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic push_model(input logic [31:0] a, input int len);
        logic [31:0] ad;
        int rem, b, bnd;
        ad  = a;
        rem = len + 1;
        while (rem > 0) begin
            b = rem;
            if (b > 16) b = 16;
            bnd = (4096 - int'(ad & 32'hFFF)) / 4;
            if (b > bnd) b = bnd;
            exp_ar_addr.push_back(ad);
            exp_ar_len.push_back(4'(b - 1));
            ad  = ad + 32'(b * 4);
            rem = rem - b;
        end
        for (int i = 0; i <= len; i++) exp_r.push_back(i == len);
    endtask

    task automatic issue_cmd(input logic [31:0] a, input logic [7:0] len);
        bit ok;
        ok = 1'b0;
        push_model(a, int'(len));
        in_ar_addr  = a;
        in_ar_len   = len;
        in_ar_valid = 1'b1;
        repeat (200) if (!ok) begin
            @(negedge clk);
            ok = in_ar_ready;
        end
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL ar_accept: got in_ar_ready 0 for 200 cycles, required acceptance");
        end
        @(posedge clk);
        #1;
        in_ar_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        bit done;
        done = 1'b0;
        repeat (3000) if (!done) begin
            @(posedge clk);
            #1;
            done = (exp_ar_addr.size() == 0) && (exp_r.size() == 0);
        end
        n_cmp++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d sub-bursts and %0d beats outstanding, required 0 and 0",
                     name, exp_ar_addr.size(), exp_r.size());
        end
    endtask

    task automatic check_reset_outputs(input string name);
        n_cmp++;
        if (in_ar_ready !== 1'b1 || out_ar_valid !== 1'b0 || out_ar_addr !== 32'h0 ||
            out_ar_len !== 4'h0 || in_r_valid !== 1'b0 || in_r_last !== 1'b0 || out_r_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got ar_rdy %b ar_vld %b addr %h len %0d r_vld %b r_last %b r_rdy %b, required 1 0 0 0 0 0 0",
                     name, in_ar_ready, out_ar_valid, out_ar_addr, out_ar_len, in_r_valid, in_r_last, out_r_ready);
        end
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        in_ar_valid  = 1'b0;
        in_ar_addr   = '0;
        in_ar_len    = '0;
        in_r_ready   = 1'b1;
        out_ar_ready = 1'b1;
        out_r_valid  = 1'b0;
        out_r_last   = 1'b0;
        out_r_data   = '0;
        out_r_resp   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset_state");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("post_reset_idle");
        @(posedge clk);
        #1;
    endtask

    task automatic test_long_burst();
        issue_cmd(32'h1000, 8'd63);
        @(negedge clk);
        n_cmp++;
        if (out_ar_valid !== 1'b1 || in_ar_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL long_first_issue: got ar_vld %b in_ar_rdy %b, required 1 0", out_ar_valid, in_ar_ready);
        end
        @(posedge clk);
        #1;
        drain("long");
    endtask

    task automatic test_boundary();
        issue_cmd(32'h0FF8, 8'd7);
        drain("boundary");
    endtask

    task automatic test_single();
        issue_cmd(32'h20, 8'd0);
        @(negedge clk);
        n_cmp++;
        if (out_ar_valid !== 1'b1 || in_ar_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL single_n1: got ar_vld %b in_ar_rdy %b, required 1 0", out_ar_valid, in_ar_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (in_ar_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_ready_back: got in_ar_ready %b, required 1", in_ar_ready);
        end
        @(posedge clk);
        #1;
        drain("single");
    endtask

    task automatic test_fifo_full();
        int  base;
        bit  seen;
        base     = ar_hs_count;
        r_credit = 0;
        issue_cmd(32'h0, 8'd127);
        repeat (12) @(posedge clk);
        #1;
        @(negedge clk);
        n_cmp++;
        if (ar_hs_count - base !== 4 || out_ar_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL full_stall: got %0d issued ar_vld %b, required 4 issued ar_vld 0", ar_hs_count - base, out_ar_valid);
        end
        @(posedge clk);
        #1;
        r_credit = 1;
        seen = 1'b0;
        repeat (100) if (!seen) begin
            @(negedge clk);
            seen = out_r_valid && out_r_ready && out_r_last;
        end
        n_cmp++;
        if (!seen) begin
            n_fail++;
            $display("FAIL full_release: got no sub-burst completion, required one");
        end
        @(negedge clk);
        n_cmp++;
        if (out_ar_valid !== 1'b1 || out_ar_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL full_reissue: got ar_vld %b addr %h, required 1 00000100", out_ar_valid, out_ar_addr);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        n_cmp++;
        if (out_ar_valid !== 1'b0 || ar_hs_count - base !== 5) begin
            n_fail++;
            $display("FAIL full_refill: got ar_vld %b issued %0d, required 0 and 5", out_ar_valid, ar_hs_count - base);
        end
        @(posedge clk);
        #1;
        r_credit = 1000000;
        drain("full");
    endtask

    task automatic test_ar_stall();
        issue_cmd(32'h2000, 8'd47);
        @(posedge clk);
        #1;
        out_ar_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (out_ar_valid !== 1'b1 || out_ar_addr !== 32'h2040 || out_ar_len !== 4'd15) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got vld %b addr %h len %0d, required 1 00002040 15",
                         k, out_ar_valid, out_ar_addr, out_ar_len);
            end
        end
        @(posedge clk);
        #1;
        out_ar_ready = 1'b1;
        drain("stall");
    endtask

    task automatic test_reset_mid();
        int base;
        bit ok;
        base       = ar_hs_count;
        in_r_ready = 1'b0;
        issue_cmd(32'h3000, 8'd63);
        ok = 1'b0;
        repeat (50) if (!ok) begin
            @(posedge clk);
            #1;
            ok = (ar_hs_count >= base + 2);
        end
        out_ar_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (!ok || out_ar_valid !== 1'b1 || out_ar_addr !== 32'h3080 || in_r_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pre: got issued %0d ar_vld %b addr %h r_vld %b, required 2 1 00003080 1",
                     ar_hs_count - base, out_ar_valid, out_ar_addr, in_r_valid);
        end
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_async_reset");
        exp_ar_addr.delete();
        exp_ar_len.delete();
        exp_r.delete();
        pend.delete();
        beat_idx = 0;
        rcnt     = 0;
        mcnt     = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n        = 1'b1;
        in_r_ready   = 1'b1;
        out_ar_ready = 1'b1;
        @(posedge clk);
        #1;
        issue_cmd(32'h40, 8'd0);
        drain("after_reset");
    endtask

    initial begin
        test_reset();
        test_long_burst();
        test_boundary();
        test_single();
        test_fifo_full();
        test_ar_stall();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
